dmem_lsu: RTL and testbench

Load/store sequencer sitting directly upstream of the single-port data RAM in the RV32 core. It accepts byte-addressed load/store requests from the execute stage, translates them to word accesses, and implements sub-word stores as read-modify-write, since the RAM has no byte enables. It performs load lane selection and sign/zero extension, and returns one response per request over a valid/ready handshake.

---
 rtl/dmem_lsu.sv | 157 +++++++++++++++
 tb/tb_dmem_lsu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed load/store sequencer for a single-port data RAM that has no byte enables.
// Latency: response is registered 2 cycles after accept for loads and SW, 3 for SB/SH (RMW), 1 for faults.
// Backpressure: one request in flight; req_ready only in IDLE, the response is held until rsp_ready.
// Build option LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of being force-aligned.
module dmem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  output logic                  mem_regce,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

  state_t state, state_nxt;

  // Request captured at accept; the address is kept as a byte address inside the RAM window.
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;

  logic                  req_half, req_word;
  logic                  oor_fault, f3_fault, mis_fault, fault;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic                  is_word_q;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] merged;

  assign req_half  = (req_funct3[1:0] == 2'b01);
  assign req_word  = (req_funct3[1:0] == 2'b10);
  assign is_word_q = (f3_q[1:0] == 2'b10);

  // Fault classification of the incoming request: range, funct3 legality, alignment.
  always_comb begin
    oor_fault = |req_addr[31:ADDR_WIDTH+2];
    if (req_we)
      f3_fault = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      f3_fault = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_fault = (req_half & req_addr[0]) | (req_word & (|req_addr[1:0]));
  assign acc_addr  = req_addr[ADDR_WIDTH+1:0];
`else
  // Misaligned halfword/word accesses silently drop the offending low address bits.
  assign mis_fault = 1'b0;
  assign acc_addr  = {req_addr[ADDR_WIDTH+1:2],
                      req_addr[1] & ~req_word,
                      req_addr[0] & ~req_half & ~req_word};
`endif

  assign fault = oor_fault | f3_fault | mis_fault;

  // Load lane selection and sign/zero extension (little-endian).
  always_comb begin
    ld_byte = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_dout[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_dout;
    endcase
  end

  // Sub-word store merge: replace the addressed lane of the old word, keep the rest.
  always_comb begin
    merged = mem_dout;
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: faults skip the RAM entirely, sub-word stores take an extra write cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = fault ? RESP : ACCESS;
      ACCESS:  state_nxt = (we_q && !is_word_q) ? RMW_WR : RESP;
      RMW_WR:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the RAM is written only by SW in ACCESS or by RMW_WR.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_regce = (state == ACCESS) || (state == RMW_WR);
    mem_addr  = addr_q[ADDR_WIDTH+1:2];
    mem_we    = 1'b0;
    mem_din   = '0;
    if (state == ACCESS && we_q && is_word_q) begin
      mem_we  = 1'b1;
      mem_din = wdata_q;
    end else if (state == RMW_WR) begin
      mem_we  = 1'b1;
      mem_din = merge_q;
    end
  end

  // Request capture, load data capture and merge-word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        addr_q    <= acc_addr;
        wdata_q   <= req_wdata;
        rsp_err   <= fault;
        rsp_rdata <= '0;
      end
      if (state == ACCESS) begin
        if (!we_q) rsp_rdata <= ld_data;
        merge_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized + directed bench for dmem_lsu against a byte-array memory model.
// Latency: each request is checked for response cycle count, data, error and RAM write count.
// Backpressure: rsp_ready is held low for random stretches to check response stability.
`timescale 1ns/1ps
module tb_dmem_lsu;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_regce;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_regce(mem_regce),
    .mem_dout(mem_dout)
  );

  // Low-latency RAM: combinational read, write on the clock edge; a preload port fills it.
  logic [31:0]   ram [1024];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_idx = '0;
  logic [31:0]   ld_dat = '0;
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_dat;
    else if (mem_we) ram[mem_addr] <= mem_din;
  end

  int we_cnt = 0;
  always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  // Reference memory as plain bytes, byte address 0..4095.
  logic [7:0] ref_mem [4096];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural model of one request: expected data, error, latency and number of RAM writes.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat, output int nwr);
    int unsigned size;
    int unsigned a;
    logic [31:0] v;
    rd = 0; err = 0; lat = 1; nwr = 0;
    size = 1 << f3[1:0];
    if (addr >= 32'd4096) err = 1;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1;
    a = addr;
    if (!err && (a % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1;
`else
      a = a - (a % size);
`endif
    end
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(size); i++) ref_mem[a + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      nwr = 1;
    end else begin
      v = 0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = ref_mem[a + i];
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
      lat = 2;
    end
  endtask

  // Issue one request, wait (bounded) for the response, hold rsp_ready low 'hold' cycles, check all.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, output logic [31:0] got_rd);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat, e_nwr, lat, w0;
    bit          busy_bad, stab_bad;
    logic [31:0] s_rd;
    logic        s_err;
    ref_access(we, f3, addr, wd, e_rd, e_err, e_lat, e_nwr);
    @(negedge clk);
    check_val("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    w0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    busy_bad = 0; stab_bad = 0; lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      if (req_ready) busy_bad = 1;
      lat++;
      @(negedge clk);
    end
    check_val("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check_val("latency", 32'(lat), 32'(e_lat));
    s_rd = rsp_rdata; s_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_rdata !== s_rd || rsp_err !== s_err || rsp_valid !== 1'b1) stab_bad = 1;
      if (req_ready) busy_bad = 1;
    end
    if (req_ready) busy_bad = 1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = $urandom_range(0, 1);
    check_val("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check_val("rsp_rdata", rsp_rdata === s_rd ? s_rd : 32'hxxxx_xxxx, e_rd);
    check_val("rsp_err", 32'(s_err), 32'(e_err));
    check_val("req_ready_busy", 32'(busy_bad), 32'd0);
    check_val("rsp_stable", 32'(stab_bad), 32'd0);
    check_val("mem_we_pulses", 32'(we_cnt - w0), 32'(e_nwr));
    rsp_ready = 1'b0;
    got_rd = s_rd;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] v;
    logic [2:0]  f3;
    logic [31:0] a;
    int          w0, nbad;
    logic [2:0]  legal_ld [5];
    legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2; legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;

    // Reset values while reset is held.
    #2;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_din", mem_din, 32'd0);
    check_val("rst_mem_regce", 32'(mem_regce), 32'd0);

    // Preload RAM and model with the same random image.
    ld_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      v = $urandom;
      ld_idx = AW'(i); ld_dat = v;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = v[8*b +: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;
    rst_n = 1'b1;

    // Directed sequence.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, r);  check_val("lw_10", r, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, r);  check_val("lb_13", r, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 0, r);  check_val("lbu_13", r, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h10, 32'h0, 0, r);  check_val("lh_10", r, 32'hFFFFBEEF);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, 0, r);  check_val("lhu_12", r, 32'h0000DEAD);
    do_req(1'b1, 3'd0, 32'h11, 32'h55, 0, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, r);  check_val("lw_after_sb", r, 32'hDEAD55EF);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 0, r);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0, 0, r); check_val("lw_oor_data", r, 32'h0);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 0, r);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, r);  check_val("lw_hold", r, 32'hDEAD55EF);

    // Reset during the RMW write cycle of an SB: the RAM must keep its old word.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'hA5;
    w0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rmw_wr_cycle", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_mid_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rst_mid_no_write", 32'(we_cnt - w0), 32'd0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, r);  check_val("lw_after_rst", r, 32'hDEAD55EF);

    // Randomized traffic, mostly in a small window so loads hit earlier stores.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = $urandom_range(0, 4095);
        default: a = $urandom_range(0, 127);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        do_req(1'b1, f3, a, $urandom, $urandom_range(0, 3), r);
      end else begin
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_ld[$urandom_range(0, 4)];
        do_req(1'b0, f3, a, $urandom, $urandom_range(0, 3), r);
      end
    end

    // Whole RAM image against the model.
    nbad = 0;
    for (int i = 0; i < 1024; i++)
      if (ram[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) nbad++;
    check_val("ram_image_bad_words", 32'(nbad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
